// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM controller.
// Each granted request becomes a fixed-length read/write command followed by a one-cycle ack.
module sram_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int OP_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              ack_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              ack_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  input  logic [DATA_W-1:0] mem_data_read,
  input  logic              mem_ready,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  localparam logic [3:0] COUNT_LOAD = 4'(OP_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        count;
  logic              grant;       // port currently being served
  logic              last_grant;
  logic              is_write;

  logic              pick_1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              can_grant;

  // Port 1 wins when it is the only requester, or on contention when port 0 was served last.
  always_comb begin
    pick_1    = req_1 && (!req_0 || !last_grant);
    sel_we    = pick_1 ? we_1    : we_0;
    sel_addr  = pick_1 ? addr_1  : addr_0;
    sel_wdata = pick_1 ? wdata_1 : wdata_0;
    can_grant = mem_ready && !ack_0 && !ack_1 && (req_0 || req_1);
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      is_write       <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_data_write <= '0;
      rdata_0        <= '0;
      rdata_1        <= '0;
      ack_0          <= 1'b0;
      ack_1          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      ack_0 <= 1'b0;
      ack_1 <= 1'b0;
      case (state)
        IDLE: begin
          if (can_grant) begin
            grant          <= pick_1;
            last_grant     <= pick_1;
            is_write       <= sel_we;
            mem_address    <= sel_addr;
            mem_data_write <= sel_wdata;
            mem_write      <= sel_we;
            mem_read       <= !sel_we;
            count          <= COUNT_LOAD;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (count == 4'd0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RELEASE;
          end else begin
            count <= count - 4'd1;
          end
        end
        RELEASE: begin
          // The controller reports idle again once it has finished the access.
          if (mem_ready) begin
            if (!is_write) begin
              if (grant) rdata_1 <= mem_data_read;
              else       rdata_0 <= mem_data_read;
            end
            if (grant) ack_1 <= 1'b1;
            else       ack_0 <= 1'b1;
            state <= ACK;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a simple SRAM controller model (ready drops while commanded).
module tb_sram_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_0, we_0, req_1, we_1;
  logic [ADDR_W-1:0] addr_0, addr_1;
  logic [DATA_W-1:0] wdata_0, wdata_1;
  logic              ack_0, ack_1;
  logic [DATA_W-1:0] rdata_0, rdata_1;
  logic              mem_write, mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_write;
  logic [DATA_W-1:0] mem_data_read;
  logic              mem_ready = 1'b1;
  logic              busy;

  logic              hold_ready = 1'b0;
  logic [DATA_W-1:0] ctrl_rdata = '0;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Controller model: busy while a command is seen, idle again the cycle after it drops.
  always @(posedge clk) mem_ready <= !hold_ready && !(mem_read || mem_write);
  assign mem_data_read = ctrl_rdata;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .ack_0(ack_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .ack_1(ack_1), .rdata_1(rdata_1),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_write(mem_data_write), .mem_data_read(mem_data_read),
    .mem_ready(mem_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the given port's ack; counts command cycles and address/data errors on the way.
  task automatic wait_ack(input bit port, input int max_cycles,
                          input logic [ADDR_W-1:0] exp_addr, input logic [DATA_W-1:0] exp_wdata,
                          output int cycles, output int rd_cnt, output int wr_cnt,
                          output int bad, output int other_ack);
    cycles = 0; rd_cnt = 0; wr_cnt = 0; bad = 0; other_ack = 0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      cycles++;
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if ((mem_read || mem_write) && mem_address !== exp_addr) bad++;
      if (mem_write && mem_data_write !== exp_wdata) bad++;
      if (port ? ack_0 : ack_1) other_ack++;
      if (port ? ack_1 : ack_0) return;
    end
    cycles = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rd, wr, bad, oth, n_acks, both, long_ack, cmd, dup;
    logic prev0, prev1;
    logic [1:0] order [8];

    reset_n = 1'b0;
    req_0 = 0; we_0 = 0; addr_0 = '0; wdata_0 = '0;
    req_1 = 0; we_1 = 0; addr_1 = '0; wdata_1 = '0;
    repeat (3) tick();
    check("rst_mem_read",  32'(mem_read),    32'h0);
    check("rst_mem_write", 32'(mem_write),   32'h0);
    check("rst_busy",      32'(busy),        32'h0);
    check("rst_acks",      32'({ack_1, ack_0}), 32'h0);
    check("rst_rdata",     32'({rdata_1, rdata_0}), 32'h0);
    check("rst_addr",      32'(mem_address), 32'h0);
    reset_n = 1'b1;
    tick();

    // Single read on port 0
    ctrl_rdata = 16'hBEEF;
    req_0 = 1; we_0 = 0; addr_0 = 18'h00010;
    wait_ack(0, 20, 18'h00010, '0, cyc, rd, wr, bad, oth);
    req_0 = 0;
    check("rd_latency",   32'(cyc), 32'd6);
    check("rd_cmd_len",   32'(rd),  32'd3);
    check("rd_no_write",  32'(wr),  32'd0);
    check("rd_addr",      32'(bad), 32'd0);
    check("rd_other_ack", 32'(oth), 32'd0);
    check("rd_rdata_0",   32'(rdata_0), 32'hBEEF);
    tick();
    check("rd_ack_pulse", 32'(ack_0), 32'h0);
    check("rd_busy_idle", 32'(busy),  32'h0);

    // Single write on port 1
    req_1 = 1; we_1 = 1; addr_1 = 18'h3FFFF; wdata_1 = 16'hA5A5;
    wait_ack(1, 20, 18'h3FFFF, 16'hA5A5, cyc, rd, wr, bad, oth);
    req_1 = 0;
    check("wr_latency",   32'(cyc), 32'd6);
    check("wr_cmd_len",   32'(wr),  32'd3);
    check("wr_no_read",   32'(rd),  32'd0);
    check("wr_addr_data", 32'(bad), 32'd0);
    check("wr_other_ack", 32'(oth), 32'd0);
    check("wr_rdata_1",   32'(rdata_1), 32'h0);
    check("wr_rdata_0",   32'(rdata_0), 32'hBEEF);
    tick();

    // Contention: both ports held high for 8 transactions
    ctrl_rdata = 16'h1234;
    we_0 = 0; addr_0 = 18'h00020; we_1 = 0; addr_1 = 18'h00030;
    for (int i = 0; i < 8; i++) order[i] = 2'b11;
    n_acks = 0; both = 0; long_ack = 0; prev0 = 0; prev1 = 0;
    req_0 = 1; req_1 = 1;
    for (int i = 0; i < 200 && n_acks < 8; i++) begin
      tick();
      if (ack_0 && ack_1) both++;
      if ((ack_0 && prev0) || (ack_1 && prev1)) long_ack++;
      if (ack_0 || ack_1) begin
        order[n_acks] = {1'b0, ack_1};
        n_acks++;
      end
      prev0 = ack_0; prev1 = ack_1;
    end
    req_0 = 0; req_1 = 0;
    check("cont_acks", 32'(n_acks), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("cont_order_%0d", i), 32'(order[i]), 32'(i % 2));
    check("cont_dual_ack",  32'(both),     32'd0);
    check("cont_ack_width", 32'(long_ack), 32'd0);
    check("cont_rdata_1",   32'(rdata_1),  32'h1234);
    tick(); tick();

    // Controller not ready: no command until mem_ready rises
    ctrl_rdata = 16'h0F0F;
    hold_ready = 1;
    tick();
    req_0 = 1; we_0 = 0; addr_0 = 18'h00ABC;
    cmd = 0;
    repeat (10) begin
      tick();
      if (mem_read || mem_write) cmd++;
    end
    check("nrdy_no_cmd", 32'(cmd),  32'd0);
    check("nrdy_busy",   32'(busy), 32'h0);
    hold_ready = 0;
    tick();
    check("nrdy_rise_no_cmd", 32'(mem_read), 32'h0);
    tick();
    check("nrdy_grant_next", 32'(mem_read), 32'h1);
    wait_ack(0, 20, 18'h00ABC, '0, cyc, rd, wr, bad, oth);
    req_0 = 0;
    check("nrdy_ack_seen", 32'(cyc > 0), 32'h1);
    check("nrdy_rdata_0",  32'(rdata_0), 32'h0F0F);
    tick();

    // Reset during ISSUE
    req_0 = 1; we_0 = 0; addr_0 = 18'h00055;
    tick(); tick();
    check("mid_cmd_active", 32'(mem_read), 32'h1);
    check("mid_busy",       32'(busy),     32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_read",  32'({mem_read, mem_write}), 32'h0);
    check("mid_rst_busy",  32'(busy),        32'h0);
    check("mid_rst_acks",  32'({ack_1, ack_0}), 32'h0);
    check("mid_rst_addr",  32'(mem_address), 32'h0);
    req_0 = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    ctrl_rdata = 16'hC0DE;
    req_0 = 1; we_0 = 0; addr_0 = 18'h00066;
    req_1 = 1; we_1 = 1; addr_1 = 18'h00077; wdata_1 = 16'h1111;
    tick();
    check("post_rst_port0_first", 32'({mem_write, mem_read}), 32'h1);
    check("post_rst_addr",        32'(mem_address), 32'h66);
    wait_ack(0, 20, 18'h00066, '0, cyc, rd, wr, bad, oth);
    req_0 = 0;
    check("post_rst_ack0",      32'(cyc > 0), 32'h1);
    check("post_rst_rdata_0",   32'(rdata_0), 32'hC0DE);
    wait_ack(1, 20, 18'h00077, 16'h1111, cyc, rd, wr, bad, oth);
    req_1 = 0;
    check("post_rst_wr_len",    32'(wr),  32'd3);
    check("post_rst_wr_bad",    32'(bad), 32'd0);
    check("post_rst_other_ack", 32'(oth), 32'd0);
    check("post_rst_rdata_1",   32'(rdata_1), 32'h0);
    tick();

    // Back-to-back on port 0
    ctrl_rdata = 16'h1357;
    req_0 = 1; we_0 = 0; addr_0 = 18'h00100;
    wait_ack(0, 20, 18'h00100, '0, cyc, rd, wr, bad, oth);
    req_0 = 0;
    check("b2b_first_latency", 32'(cyc), 32'd6);
    check("b2b_first_rdata",   32'(rdata_0), 32'h1357);
    ctrl_rdata = 16'h5A5A;
    dup = 0;
    repeat (2) begin
      tick();
      if (mem_read || mem_write || busy || ack_0) dup++;
    end
    check("b2b_no_dup_grant", 32'(dup), 32'd0);
    req_0 = 1; addr_0 = 18'h00101;
    wait_ack(0, 20, 18'h00101, '0, cyc, rd, wr, bad, oth);
    req_0 = 0;
    check("b2b_second_latency", 32'(cyc), 32'd6);
    check("b2b_second_len",     32'(rd),  32'd3);
    check("b2b_second_rdata",   32'(rdata_0), 32'h5A5A);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port round-robin arbiter that shares one SRAM controller (level-held read/write request, ready = idle) between two requesters, e.g. a pixel/video reader and a host/CPU port.
- Converts each requester's req/ack transaction into a controller request of fixed length, then returns read data and a one-cycle ack.
- Sits between the requesting logic and the SRAM controller. It is the only driver of the controller's command, address and write-data inputs.

Parameters:
- ADDR_W, 18, address width (SRAM word address)
- DATA_W, 16, data width
- OP_CYCLES, 3, cycles mem_read/mem_write are held high per access. Legal values are 2..15; 3 is required for reads (controller setup + capture).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_0  in  1  port 0 request; held high until ack_0
- we_0  in  1  port 0: 1 = write, 0 = read; sampled at grant
- addr_0  in  ADDR_W  port 0 address; sampled at grant
- wdata_0  in  DATA_W  port 0 write data; sampled at grant
- ack_0  out  1  port 0 done, one-cycle pulse
- rdata_0  out  DATA_W  port 0 read data; valid with ack_0, held until next port-0 read ack
- req_1, we_1, addr_1, wdata_1, ack_1, rdata_1: same as port 0, for port 1
- mem_write  out  1  to controller write
- mem_read  out  1  to controller read
- mem_address  out  ADDR_W  to controller address
- mem_data_write  out  DATA_W  to controller write data
- mem_data_read  in  DATA_W  from controller read data
- mem_ready  in  1  from controller; high when controller is idle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; mem_read, mem_write, ack_0, ack_1, busy = 0.
  - mem_address, mem_data_write, rdata_0, rdata_1 = 0.
  - last_grant = 1, so port 0 wins the first contention.
- All outputs are registered.
- States: IDLE, ISSUE, RELEASE, ACK.
- IDLE:
  - Grant only if mem_ready = 1, no ack is currently high, and at least one req is high.
  - One req high: grant that port.
  - Both high: grant the port != last_grant.
  - At grant, latch we/addr/wdata into mem_* registers, assert mem_write (we = 1) or mem_read (we = 0), set last_grant, load count = OP_CYCLES-1, and go to ISSUE.
- ISSUE:
  - Command stays high.
  - Each cycle, count decrements. At count == 0, drop the command and go to RELEASE.
  - Net effect: the command is high for exactly OP_CYCLES consecutive cycles. mem_address and mem_data_write are stable throughout.
- RELEASE:
  - Wait for mem_ready = 1. The controller returns to idle one cycle after the command drops.
  - When mem_ready = 1: for a read, latch mem_data_read into rdata of the granted port. Then go to ACK.
- ACK:
  - ack of the granted port is high for exactly this one cycle. Go to IDLE.
- Turnaround:
  - Requester drops req on the edge at which it sees ack.
  - IDLE ignores reqs in the cycle ack is high, so a just-acked req is never re-granted.
  - Minimum transaction time, req to ack: OP_CYCLES + 3 cycles.
- Fairness: with both ports continuously requesting, grants alternate 0, 1, 0, 1. There is no starvation.
- Non-granted req has no effect until the current transaction completes. Req changes of the granted port after grant are ignored.
- mem_ready low at reset exit (controller still in reset): no grant until it rises.
- Writes leave rdata unchanged.
- Reset mid-transaction: everything clears immediately and the command drops asynchronously. The requester must reissue.

Test Plan:
- Single read: port 0 req, we = 0, addr = 0x00010; controller model returns 0xBEEF. Required: mem_read high exactly 3 cycles with mem_address = 0x00010, then ack_0 pulse with rdata_0 = 0xBEEF, latency 6 cycles.
- Single write: port 1 req, we = 1, addr = 0x3FFFF, wdata = 0xA5A5. Required: mem_write high 3 cycles, mem_data_write = 0xA5A5, then one ack_1 pulse; rdata_1 unchanged.
- Contention: req_0 and req_1 both raised in the same cycle after reset and held through 4 transactions each. Required: grant order 0, 1, 0, 1 …; no ack on the non-granted port; each ack is exactly 1 cycle.
- mem_ready held low for 10 cycles while req_0 is high. Required: no mem_read/mem_write until mem_ready rises; the grant then occurs on the following edge.
- Reset mid-access: assert reset_n = 0 during ISSUE. Required: mem_read/mem_write, busy and acks go to 0 immediately. After release, port 0 is granted first on contention.
- Back-to-back same port: req_0 re-raised 1 cycle after ack_0 drops. Required: a second full transaction, no duplicate grant from the first req.
